// File: rtl/uart_link.sv
// 8N1 UART: transmitter, majority-vote receive filter and receiver, all paced by one
// shared oversampling clock enable on ref_clk.
module uart_link #(
    parameter int OVERSAMPLE = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic       ref_clk,
    input  logic       reset_n,
    input  logic       samp_en,
    input  logic       tx_send,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_ready
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    function automatic logic majority(input logic [FILTER_LEN-1:0] w);
        int ones;
        ones = 0;
        for (int i = 0; i < FILTER_LEN; i++) begin
            ones += int'(w[i]);
        end
        return (ones > (FILTER_LEN / 2));
    endfunction

    logic [CW-1:0] tick_cnt;
    logic          bit_tick;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (samp_en) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign bit_tick = samp_en && (tick_cnt == FULL_LAST);

    // Transmitter
    tx_state_t  tx_state, tx_next;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (bit_tick && tx_send) tx_next = TX_START;
            TX_START: if (bit_tick) tx_next = TX_DATA;
            TX_DATA:  if (bit_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (bit_tick) tx_next = TX_DONE;
            TX_DONE:  if (!tx_send) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        txd     = 1'b1;
        tx_done = 1'b0;
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift[0];
            TX_DONE:  tx_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_bit <= '0;
        end else if (tx_state != TX_DATA) begin
            tx_bit <= '0;
        end else if (bit_tick) begin
            tx_bit <= tx_bit + 1'b1;
        end
    end

    // Byte is captured on the same bit tick that launches the start bit.
    always_ff @(posedge ref_clk) begin
        if (tx_state == TX_IDLE && tx_next == TX_START) begin
            tx_shift <= tx_data;
        end else if (tx_state == TX_DATA && bit_tick) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
    end

    // Receive line: two-flop synchronizer stages p0/p1, then the vote window
    logic                  rxd_p0, rxd_p1;
    logic [FILTER_LEN-1:0] window;
    logic                  line, line_prev;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_p0    <= 1'b1;
            rxd_p1    <= 1'b1;
            window    <= '1;
            line_prev <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
            if (samp_en) begin
                window    <= {window[FILTER_LEN-2:0], rxd_p1};
                line_prev <= line;
            end
        end
    end

    assign line = majority(window);

    // Receiver
    rx_state_t  rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_half, rx_full, rx_load, rx_clear;

    assign rx_half = (rx_cnt == HALF_LAST);
    assign rx_full = (rx_cnt == FULL_LAST);

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        if (samp_en) begin
            case (rx_state)
                RX_IDLE:  if (line_prev && !line) rx_next = RX_START;
                RX_START: if (rx_half) rx_next = line ? RX_IDLE : RX_DATA;
                RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_next = RX_STOP;
                RX_STOP:  if (rx_full) rx_next = line ? RX_IDLE : RX_WAIT;
                RX_WAIT:  if (line) rx_next = RX_IDLE;
                default:  rx_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_clear = samp_en && (rx_state == RX_IDLE) && line_prev && !line;
        rx_load  = samp_en && (rx_state == RX_STOP) && rx_full && line;
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else if (samp_en) begin
            if (rx_next != rx_state || rx_full) begin
                rx_cnt <= '0;
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (rx_state != RX_DATA) begin
                rx_bit <= '0;
            end else if (rx_full) begin
                rx_bit <= rx_bit + 1'b1;
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (samp_en && rx_state == RX_DATA && rx_full) begin
            rx_shift <= {line, rx_shift[7:1]};
        end
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else if (rx_load) begin
            rx_data  <= rx_shift;
            rx_ready <= 1'b1;
        end else if (rx_clear) begin
            rx_ready <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_link.sv
// Bench for uart_link: loopback and bit-banged frames checked against a byte-level
// model of what the receiver should have delivered.
module tb_uart_link;
    localparam int OS = 8;
    localparam int FL = 3;

    logic       ref_clk = 1'b0;
    logic       reset_n;
    logic       samp_en;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       txd;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_ready;

    logic loop = 1'b1;
    logic rxd_drv = 1'b1;
    logic stall = 1'b0;
    logic sparse = 1'b0;

    int         n_tests = 0;
    int         n_fail = 0;
    int         rise_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic       rdy_q = 1'b0;

    // Model: last byte that should be on rx_data and number of good frames so far
    logic [7:0] m_data = 8'h00;
    int         m_rises = 0;

    assign rxd = loop ? txd : rxd_drv;

    uart_link #(.OVERSAMPLE(OS), .FILTER_LEN(FL)) dut (
        .ref_clk (ref_clk),
        .reset_n (reset_n),
        .samp_en (samp_en),
        .tx_send (tx_send),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .txd     (txd),
        .rxd     (rxd),
        .rx_data (rx_data),
        .rx_ready(rx_ready)
    );

    always #5 ref_clk = ~ref_clk;

    always @(negedge ref_clk) begin
        samp_en = !stall && (!sparse || ($urandom_range(0, 2) == 0));
    end

    always @(negedge ref_clk) begin
        if (rx_ready && !rdy_q) begin
            rise_cnt++;
            last_rx = rx_data;
        end
        rdy_q = rx_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 20000) begin
            @(posedge ref_clk);
            #1;
            if (samp_en) k++;
            guard++;
        end
    endtask

    task automatic wait_txd_low();
        int g = 0;
        while (txd !== 1'b0 && g < 2000) begin
            @(posedge ref_clk);
            #1;
            g++;
        end
        chk("start_bit_seen", 32'(txd), 0);
    endtask

    task automatic send_loop(input logic [7:0] b, input logic mid_stall);
        int g;
        int lows;
        loop    = 1'b1;
        tx_data = b;
        tx_send = 1'b1;
        wait_txd_low();
        tx_data = ~b;
        if (mid_stall) begin
            wait_cycles(20);
            stall = 1'b1;
            wait_cycles(101);
            stall = 1'b0;
        end
        g = 0;
        while (tx_done !== 1'b1 && g < 4000) begin
            @(negedge ref_clk);
            g++;
        end
        chk("tx_done_rise", 32'(tx_done), 1);
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge ref_clk);
            if (txd == 1'b0) lows++;
        end
        chk("no_repeat_frame", lows, 0);
        chk("tx_done_held", 32'(tx_done), 1);
        m_data = b;
        m_rises++;
        chk("rx_rise_count", rise_cnt, m_rises);
        chk("rx_byte_at_rise", 32'(last_rx), 32'(b));
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("rx_ready", 32'(rx_ready), 1);
        tx_send = 1'b0;
        @(posedge ref_clk);
        #1;
        chk("tx_done_clear", 32'(tx_done), 0);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr   = {stop, b, 1'b0};
        loop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rxd_drv = fr[i];
            wait_ticks(OS);
        end
        rxd_drv = 1'b1;
        wait_ticks(3 * OS);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        tx_send = 1'b0;
        tx_data = 8'h00;
        wait_cycles(3);
        chk("rst_hold_txd", 32'(txd), 1);
        wait_cycles(13);
        @(negedge ref_clk);
        reset_n = 1'b1;
        wait_cycles(16);
        chk("rst_txd", 32'(txd), 1);
        chk("rst_tx_done", 32'(tx_done), 0);
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_rx_data", 32'(rx_data), 0);

        send_loop(8'hA9, 1'b0);
        send_loop(8'h99, 1'b0);

        stall = 1'b1;
        wait_cycles(101);
        chk("stall_txd", 32'(txd), 1);
        chk("stall_rx_ready", 32'(rx_ready), 1);
        stall = 1'b0;
        send_loop(8'hB1, 1'b1);
        send_loop(8'hEA, 1'b0);

        loop    = 1'b0;
        rxd_drv = 1'b0;
        wait_ticks(1);
        rxd_drv = 1'b1;
        wait_ticks(3 * OS);
        chk("glitch_rx_ready", 32'(rx_ready), 1);
        chk("glitch_rises", rise_cnt, m_rises);
        chk("glitch_rx_data", 32'(rx_data), 32'(m_data));

        rxd_drv = 1'b0;
        wait_ticks(OS / 2 - 1);
        rxd_drv = 1'b1;
        wait_ticks(3 * OS);
        chk("false_start_ready", 32'(rx_ready), 0);
        chk("false_start_rises", rise_cnt, m_rises);
        chk("false_start_data", 32'(rx_data), 32'(m_data));

        drive_frame(8'hC3, 1'b0);
        chk("frame_err_ready", 32'(rx_ready), 0);
        chk("frame_err_rises", rise_cnt, m_rises);
        chk("frame_err_data", 32'(rx_data), 32'(m_data));

        drive_frame(8'h55, 1'b1);
        m_data = 8'h55;
        m_rises++;
        chk("after_err_rises", rise_cnt, m_rises);
        chk("after_err_data", 32'(rx_data), 32'(m_data));
        chk("after_err_ready", 32'(rx_ready), 1);

        // 0x5A: bit 2 is 0, so txd is low at the moment reset hits
        loop    = 1'b1;
        tx_data = 8'h5A;
        tx_send = 1'b1;
        wait_txd_low();
        wait_cycles(28);
        chk("mid_reset_pre_txd", 32'(txd), 0);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_txd", 32'(txd), 1);
        chk("mid_reset_tx_done", 32'(tx_done), 0);
        chk("mid_reset_rx_ready", 32'(rx_ready), 0);
        tx_send = 1'b0;
        wait_cycles(16);
        @(negedge ref_clk);
        reset_n = 1'b1;
        wait_cycles(100);
        m_data = 8'h00;
        chk("post_reset_txd", 32'(txd), 1);
        chk("post_reset_ready", 32'(rx_ready), 0);
        chk("post_reset_rises", rise_cnt, m_rises);
        chk("post_reset_data", 32'(rx_data), 32'(m_data));
        send_loop(8'h3C, 1'b0);

        sparse = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_loop(8'($urandom), (i == 1));
        end
        sparse = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_link.md
Name: uart_link

Overview:
- Single-clock 8N1 UART block: transmitter, receive-line glitch filter and receiver behind one shared oversampling tick.
- Sits between a parallel byte interface and the serial txd/rxd pins; tying txd to rxd gives a self-test loopback.
- All logic runs on ref_clk; serial timing comes from the samp_en clock enable.

Parameters:
- OVERSAMPLE, 8: samp_en ticks per bit; must be a power of two, at least 4.
- FILTER_LEN, 3: rxd majority-vote window in samp_en ticks; odd, 3 or 5.

Ports:
- ref_clk  in  1  sole clock; everything on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- samp_en  in  1  oversampling tick, one ref_clk cycle wide; may stall for any length.
- tx_send  in  1  level request to transmit tx_data.
- tx_data  in  8  byte to send; sampled when a frame starts.
- tx_done  out 1  frame fully sent; high until tx_send drops.
- txd      out 1  serial output; idle high.
- rxd      in  1  serial input, asynchronous.
- rx_data  out 8  last correctly framed byte.
- rx_ready out 1  rx_data valid.

Behaviour:
- Reset values: txd=1, tx_done=0, rx_ready=0, rx_data=0, filtered line=1; TX and RX idle; tick counters 0.
- State only advances on cycles with samp_en=1. Stalling samp_en freezes everything except the async reset, with no loss or corruption.
- Bit tick: a free-running OVERSAMPLE counter on samp_en; bit_tick when it wraps.
- TX states IDLE -> START -> DATA(8) -> STOP -> DONE:
  - In IDLE with tx_send=1 and tx_done=0, latch tx_data and go to START on the next bit_tick.
  - Each state holds txd for exactly one bit period: START drives 0, DATA drives bits LSB first, STOP drives 1.
  - At the end of STOP, tx_done=1.
  - tx_done clears the cycle after tx_send is seen low. A new frame needs tx_send low then high; holding tx_send high never repeats a frame.
  - tx_send dropping mid-frame does not abort the frame.
- Filter:
  - 2-flop synchronizer on rxd.
  - Shift the synchronized value into a FILTER_LEN window on samp_en.
  - Output is the majority of the window; it changes only when the majority changes.
  - Any pulse shorter than (FILTER_LEN+1)/2 ticks is suppressed.
  - Latency: 2 ref_clk plus about (FILTER_LEN+1)/2 samp_en.
- RX states IDLE -> START -> DATA -> STOP, all on the filtered line:
  - IDLE: a falling edge (1 then 0) enters START and clears rx_ready. rx_data keeps its old value until overwritten.
  - START: after OVERSAMPLE/2 ticks (mid-bit), a line still at 0 goes to DATA; a line back at 1 is a false start and returns to IDLE.
  - DATA: sample every OVERSAMPLE ticks and shift in LSB first, 8 bits.
  - STOP: after OVERSAMPLE ticks, line=1 loads rx_data and sets rx_ready=1, then IDLE.
  - STOP with line=0 is a framing error: no ready, rx_data unchanged. Stay in IDLE-wait until the line has been 1 for one tick before re-arming edge detect.
- rx_ready stays high until the next start edge or reset, so it rises once per good frame.
- TX and RX are independent; full duplex is allowed.
- reset_n low mid-frame returns to idle immediately: txd=1 and any partial RX byte is discarded.

Test Plan:
- Reset: hold reset_n=0 for 2 bit periods, then release and wait 2 bit periods -> tx_done=0, rx_ready=0, txd=1.
- Loopback with txd tied to rxd and samp_en every cycle:
  - Send 0xA9 -> tx_done rises; drop tx_send.
  - rx_ready then rises with rx_data=0xA9.
  - Repeat with 0x99.
- Stall: hold samp_en low for 101 ref_clk between frames, then send 0xB1 and 0xEA -> each received exactly, one rx_ready rise per byte.
- Glitch: a 1-tick low pulse on rxd while idle -> no frame started, rx_ready unchanged.
  - A low pulse of OVERSAMPLE/2 - 1 ticks -> treated as a false start.
- Framing error: drive a frame with stop bit 0 -> rx_ready stays 0 and rx_data holds its previous value.
  - A following good frame 0x55 is then received.
- Mid-frame reset: assert reset_n mid-TX and mid-RX -> txd=1 at once, no ready.
  - The next frame after release works normally.
